// File: rtl/timer_pkg.sv
// Shared types and constants for the stopwatch timebase.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUNNING   = 2'd1,
    ST_PAUSED    = 2'd2,
    ST_SATURATED = 2'd3
  } sw_state_e;

  localparam int TIME_W_DEFAULT = 39;
  localparam logic [TIME_W_DEFAULT-1:0] TIME_MAX = '1;

endpackage

// File: rtl/stopwatch_timebase_prescaler.sv
// Divides clk down to one unit strobe every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Wrap strobe; the owner of the time counter registers it.
  assign tick = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_timebase.sv
// Stopwatch core: button edge detect, run/pause/clear FSM, saturating
// elapsed-time counter and lap capture.
//
// state        | meaning
// ST_IDLE      | cleared, waiting for start
// ST_RUNNING   | prescaler counting, time_out advancing
// ST_PAUSED    | time and partial unit frozen
// ST_SATURATED | time_out pinned at all-ones until clear
module stopwatch_timebase
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int TIME_W   = timer_pkg::TIME_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_stop,
  input  logic              clear,
  input  logic              lap,
  output logic [TIME_W-1:0] time_out,
  output logic [TIME_W-1:0] lap_time,
  output logic              running,
  output logic              tick,
  output logic              overflow
);

  localparam logic [TIME_W-1:0] TIME_LIM = '1;

  sw_state_e state;
  logic      ss_q, clr_q, lap_q;
  logic      armed;
  logic      press_ss, press_clr, press_lap;
  logic      unit_wrap;
  logic      presc_en, presc_clr;

  // armed masks the first edge after reset so a held button never counts.
  assign press_ss  = start_stop & ~ss_q  & armed;
  assign press_clr = clear      & ~clr_q & armed;
  assign press_lap = lap        & ~lap_q & armed;

  assign presc_en  = (state == ST_RUNNING) && !press_clr;
  assign presc_clr = press_clr || (state == ST_IDLE) || (state == ST_SATURATED);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (presc_en),
    .clr    (presc_clr),
    .tick   (unit_wrap)
  );

  assign running  = (state == ST_RUNNING);
  assign overflow = (state == ST_SATURATED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      time_out <= '0;
      lap_time <= '0;
      tick     <= 1'b0;
      ss_q     <= 1'b0;
      clr_q    <= 1'b0;
      lap_q    <= 1'b0;
      armed    <= 1'b0;
    end else begin
      ss_q  <= start_stop;
      clr_q <= clear;
      lap_q <= lap;
      armed <= 1'b1;
      tick  <= 1'b0;
      if (press_clr) begin
        state    <= ST_IDLE;
        time_out <= '0;
        lap_time <= '0;
      end else begin
        if (press_lap && (state != ST_IDLE)) lap_time <= time_out;
        case (state)
          ST_IDLE: if (press_ss) state <= ST_RUNNING;
          ST_RUNNING: begin
            // Saturation outranks a coincident pause request.
            if (unit_wrap && (time_out == TIME_LIM)) begin
              state <= ST_SATURATED;
            end else begin
              if (unit_wrap) begin
                time_out <= time_out + TIME_W'(1);
                tick     <= 1'b1;
              end
              if (press_ss) state <= ST_PAUSED;
            end
          end
          ST_PAUSED: if (press_ss) state <= ST_RUNNING;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Bench for stopwatch_timebase: directed vector table, saturation sequence
// and randomized buttons, all checked against a cycle-count reference model.
module tb_stopwatch_timebase;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_SAT = 3;
  localparam longint A_DIV = 4, B_DIV = 2;
  localparam longint A_MAX = (longint'(1) << 39) - 1;
  localparam longint B_MAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b1, a_ss = 1'b0, a_clr = 1'b0, a_lap = 1'b0;
  logic [38:0] a_time, a_lapt;
  logic        a_run, a_tick, a_ovf;
  logic        b_rst = 1'b1, b_ss = 1'b0, b_clr = 1'b0, b_lap = 1'b0;
  logic [3:0]  b_time, b_lapt;
  logic        b_run, b_tick, b_ovf;

  stopwatch_timebase #(.TICK_DIV(4), .TIME_W(39)) dut_a (
    .clk(clk), .reset(a_rst), .start_stop(a_ss), .clear(a_clr), .lap(a_lap),
    .time_out(a_time), .lap_time(a_lapt), .running(a_run), .tick(a_tick),
    .overflow(a_ovf));

  stopwatch_timebase #(.TICK_DIV(2), .TIME_W(4)) dut_b (
    .clk(clk), .reset(b_rst), .start_stop(b_ss), .clear(b_clr), .lap(b_lap),
    .time_out(b_time), .lap_time(b_lapt), .running(b_run), .tick(b_tick),
    .overflow(b_ovf));

  // Reference: time is running cycles / TICK_DIV, capped by a saturated mode.
  typedef struct {
    int     mode;
    longint run_cyc;
    longint lap;
    bit     tick;
    bit     armed;
    bit     p_ss, p_clr, p_lap;
  } mdl_t;

  mdl_t ma, mb;
  int n_err = 0, n_chk = 0;

  function automatic longint mdl_time(mdl_t m, longint div, longint tmax);
    return (m.mode == M_SAT) ? tmax : m.run_cyc / div;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, bit rst, bit ss, bit clr, bit lp,
                                    longint div, longint tmax);
    mdl_t n;
    bit pss, pclr, plp;
    longint t_old;
    n = m;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    pss  = ss  && !m.p_ss  && m.armed;
    pclr = clr && !m.p_clr && m.armed;
    plp  = lp  && !m.p_lap && m.armed;
    n.p_ss = ss; n.p_clr = clr; n.p_lap = lp;
    n.armed = 1'b1;
    n.tick  = 1'b0;
    t_old = mdl_time(m, div, tmax);
    if (pclr) begin
      n.mode = M_IDLE; n.run_cyc = 0; n.lap = 0;
    end else begin
      if (plp && m.mode != M_IDLE) n.lap = t_old;
      if (m.mode == M_RUN) begin
        n.run_cyc = m.run_cyc + 1;
        if (n.run_cyc % div == 0) begin
          if (n.run_cyc / div > tmax) n.mode = M_SAT;
          else n.tick = 1'b1;
        end
        if (pss && n.mode == M_RUN) n.mode = M_PAUSE;
      end else if (pss && m.mode != M_SAT) begin
        n.mode = M_RUN;
      end
    end
    return n;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_mdl(string tag, mdl_t m, longint div, longint tmax,
                         logic [63:0] t, logic [63:0] lt, logic r, logic tk, logic ov);
    chk({tag, "_time"}, t, mdl_time(m, div, tmax));
    chk({tag, "_lap"}, lt, m.lap);
    chk({tag, "_running"}, 64'(r), 64'(m.mode == M_RUN));
    chk({tag, "_tick"}, 64'(tk), 64'(m.tick));
    chk({tag, "_overflow"}, 64'(ov), 64'(m.mode == M_SAT));
  endtask

  task automatic step();
    @(posedge clk);
    ma = mdl_next(ma, a_rst, a_ss, a_clr, a_lap, A_DIV, A_MAX);
    mb = mdl_next(mb, b_rst, b_ss, b_clr, b_lap, B_DIV, B_MAX);
    #1;
    chk_mdl("mdl_a", ma, A_DIV, A_MAX, a_time, a_lapt, a_run, a_tick, a_ovf);
    chk_mdl("mdl_b", mb, B_DIV, B_MAX, b_time, b_lapt, b_run, b_tick, b_ovf);
  endtask

  typedef struct {
    bit     rst, ss, clr, lp;
    int     n;
    longint t, lapt;
    bit     run, tk, ovf;
  } vec_t;

  localparam int NV = 24;
  vec_t vt[NV];

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    //          rst ss clr lp  n   time lap run tk ovf
    vt[0]  = '{1, 0, 0, 0,  2,  0, 0, 0, 0, 0};
    vt[1]  = '{0, 0, 0, 0,  1,  0, 0, 0, 0, 0};
    vt[2]  = '{0, 1, 0, 0,  1,  0, 0, 1, 0, 0};
    vt[3]  = '{0, 0, 0, 0, 40, 10, 0, 1, 1, 0};
    vt[4]  = '{0, 0, 1, 0,  1,  0, 0, 0, 0, 0};
    vt[5]  = '{0, 1, 0, 0,  1,  0, 0, 1, 0, 0};
    vt[6]  = '{0, 0, 0, 0, 13,  3, 0, 1, 0, 0};
    vt[7]  = '{0, 1, 0, 0,  1,  3, 0, 0, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 20,  3, 0, 0, 0, 0};
    vt[9]  = '{0, 1, 0, 0,  1,  3, 0, 1, 0, 0};
    vt[10] = '{0, 0, 0, 0,  1,  3, 0, 1, 0, 0};
    vt[11] = '{0, 0, 0, 0,  1,  4, 0, 1, 1, 0};
    vt[12] = '{0, 0, 0, 0, 12,  7, 0, 1, 1, 0};
    vt[13] = '{0, 0, 0, 1,  1,  7, 7, 1, 0, 0};
    vt[14] = '{0, 0, 0, 0,  7,  9, 7, 1, 1, 0};
    vt[15] = '{0, 0, 1, 1,  1,  0, 0, 0, 0, 0};
    vt[16] = '{0, 1, 0, 0, 50, 12, 0, 1, 0, 0};
    vt[17] = '{0, 0, 1, 0,  1,  0, 0, 0, 0, 0};
    vt[18] = '{0, 1, 0, 0,  1,  0, 0, 1, 0, 0};
    vt[19] = '{0, 1, 0, 0, 20,  5, 0, 1, 1, 0};
    vt[20] = '{1, 1, 0, 0,  1,  0, 0, 0, 0, 0};
    vt[21] = '{0, 1, 0, 0,  5,  0, 0, 0, 0, 0};
    vt[22] = '{0, 0, 0, 0,  1,  0, 0, 0, 0, 0};
    vt[23] = '{0, 1, 0, 0,  1,  0, 0, 1, 0, 0};

    for (int i = 0; i < NV; i++) begin
      a_rst = vt[i].rst; a_ss = vt[i].ss; a_clr = vt[i].clr; a_lap = vt[i].lp;
      repeat (vt[i].n) step();
      chk($sformatf("vec%0d_time", i), a_time, vt[i].t);
      chk($sformatf("vec%0d_lap", i), a_lapt, vt[i].lapt);
      chk($sformatf("vec%0d_running", i), 64'(a_run), 64'(vt[i].run));
      chk($sformatf("vec%0d_tick", i), 64'(a_tick), 64'(vt[i].tk));
      chk($sformatf("vec%0d_overflow", i), 64'(a_ovf), 64'(vt[i].ovf));
    end
    a_ss = 1'b0;

    // Saturation on the narrow instance.
    b_rst = 1'b0;
    step();
    b_ss = 1'b1; step(); b_ss = 1'b0;
    chk("sat_started", 64'(b_run), 64'd1);
    repeat (30) step();
    chk("sat_at_max_time", b_time, 64'd15);
    chk("sat_at_max_tick", 64'(b_tick), 64'd1);
    step();
    chk("sat_pre_time", b_time, 64'd15);
    step();
    chk("sat_time", b_time, 64'd15);
    chk("sat_tick", 64'(b_tick), 64'd0);
    chk("sat_overflow", 64'(b_ovf), 64'd1);
    chk("sat_running", 64'(b_run), 64'd0);
    b_ss = 1'b1; step(); b_ss = 1'b0; step();
    chk("sat_ss_ignored_ovf", 64'(b_ovf), 64'd1);
    chk("sat_ss_ignored_time", b_time, 64'd15);
    b_lap = 1'b1; step(); b_lap = 1'b0;
    chk("sat_lap", b_lapt, 64'd15);
    b_clr = 1'b1; step(); b_clr = 1'b0;
    chk("sat_clr_time", b_time, 64'd0);
    chk("sat_clr_ovf", 64'(b_ovf), 64'd0);
    chk("sat_clr_run", 64'(b_run), 64'd0);
    chk("sat_clr_lap", b_lapt, 64'd0);

    // Random button activity on both instances.
    for (int i = 0; i < 4000; i++) begin
      a_rst = ($urandom_range(0, 299) == 0);
      a_ss  = ($urandom_range(0, 9) < 3);
      a_clr = ($urandom_range(0, 99) < 3);
      a_lap = ($urandom_range(0, 7) == 0);
      b_rst = ($urandom_range(0, 299) == 0);
      b_ss  = ($urandom_range(0, 9) < 3);
      b_clr = ($urandom_range(0, 99) < 2);
      b_lap = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
